// File: rtl/busy_gnt_arb_pkg.sv
// -----------------------------------------------------------------------------
// busy_gnt_arb_pkg
// Shared types and constants for the busy/grant arbiter.
//   state_e         : FSM state encoding (IDLE, BUSY, GRANT)
//   BUSY_LEN_W      : width of the busy_len request field
//   MAX_BUSY_LIMIT  : largest legal value of the MAX_BUSY parameter
// -----------------------------------------------------------------------------
package busy_gnt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        GRANT = 2'd2
    } state_e;

    localparam int BUSY_LEN_W     = 3;
    localparam int MAX_BUSY_LIMIT = 7;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector.
// The search begins at start_i, which is the index following the last
// winner, and wraps around. Because of this, the previous winner is visited last.
// Ports:
//   req_i   : request vector, one bit per requester
//   start_i : first index to examine (index after the last winner)
//   idx_o   : index of the selected requester (0 when nothing is requested)
//   valid_o : high when any request bit is set
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scan from the farthest offset down to offset 0. The final hit is
    // therefore the closest one to start_i.
    always_comb begin
        logic [IDX_W-1:0] k;
        valid_o = 1'b0;
        idx_o   = '0;
        k       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IDX_W'((int'(start_i) + i) % NUM_REQ);
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = k;
            end
        end
    end

endmodule

// File: rtl/busy_gnt_arbiter.sv
// -----------------------------------------------------------------------------
// busy_gnt_arbiter
// Round-robin arbiter for a single shared resource.
// When a request is accepted, the resource stays busy for N cycles. After the
// busy phase, the owner receives a one-cycle completion grant.
//
// Handshake: a requester raises its req bit (level) and keeps it high.
// Acceptance happens in any IDLE or GRANT cycle where req is non-zero.
// busy_len is sampled at that same edge. The owner is told that its
// transaction is complete by a single-cycle gnt pulse. req is ignored while
// busy is high. A requester that keeps req high after its gnt pulse is
// re-arbitrated behind every other active requester.
//
// Parameters: NUM_REQ (2..8) requesters, MAX_BUSY (1..7) longest busy phase.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : level request per requester
//   busy_len    : requested busy length. 0 maps to 1, values above MAX_BUSY
//                 map to MAX_BUSY
//   busy        : shared resource occupied
//   gnt         : one-hot single-cycle completion grant
//   gnt_id      : current owner index (valid while busy or gnt)
//   len_clamped : one-cycle flag, sampled busy_len was out of range
//   dbg_state_o : FSM state, for observation only
// Optional: define BUSY_GNT_ARBITER_SVA_EN to embed protocol assertions.
// -----------------------------------------------------------------------------
module busy_gnt_arbiter
    import busy_gnt_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_BUSY = 5,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [BUSY_LEN_W-1:0] busy_len,
    output logic                  busy,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [IDX_W-1:0]      gnt_id,
    output logic                  len_clamped,
    output state_e                dbg_state_o
);

    localparam logic [BUSY_LEN_W-1:0] MAX_LEN = BUSY_LEN_W'(MAX_BUSY);

    state_e                  state_q;
    logic                    busy_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [IDX_W-1:0]        gnt_id_q;
    logic                    clamp_q;
    logic [BUSY_LEN_W-1:0]   cnt_q;
    logic [IDX_W-1:0]        ptr_q;

    logic [IDX_W-1:0]        win_idx;
    logic                    win_valid;
    logic                    accept_d;
    logic                    clamp_d;
    logic [BUSY_LEN_W-1:0]   eff_len_d;
    logic [IDX_W-1:0]        ptr_d;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (req),
        .start_i (ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        accept_d  = ((state_q == IDLE) || (state_q == GRANT)) && win_valid;
        clamp_d   = (busy_len == '0) || (busy_len > MAX_LEN);
        eff_len_d = busy_len;
        if (busy_len == '0) begin
            eff_len_d = BUSY_LEN_W'(1);
        end else if (busy_len > MAX_LEN) begin
            eff_len_d = MAX_LEN;
        end
        // ptr_q holds the index after the last winner, so the winner is
        // visited last on the next search.
        ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            clamp_q  <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            gnt_q   <= '0;
            clamp_q <= 1'b0;
            case (state_q)
                IDLE, GRANT: begin
                    if (accept_d) begin
                        state_q  <= BUSY;
                        busy_q   <= 1'b1;
                        gnt_id_q <= win_idx;
                        cnt_q    <= eff_len_d - BUSY_LEN_W'(1);
                        clamp_q  <= clamp_d;
                        ptr_q    <= ptr_d;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    // The counter holds the number of busy cycles left after the current one.
                    if (cnt_q == '0) begin
                        state_q         <= GRANT;
                        busy_q          <= 1'b0;
                        gnt_q[gnt_id_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - BUSY_LEN_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign len_clamped = clamp_q;
    assign dbg_state_o = state_q;

`ifdef BUSY_GNT_ARBITER_SVA_EN
    a_accept_seq: assert property (@(posedge clk) disable iff (!rst_n)
        accept_d |-> ##1 busy[*1:MAX_BUSY] ##1 (gnt != '0));

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    a_busy_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && (gnt != '0)));

    a_id_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (busy && $past(busy)) |-> $stable(gnt_id));
`endif

endmodule

// File: tb/tb_busy_gnt_arbiter.sv
module tb_busy_gnt_arbiter;
  import busy_gnt_arb_pkg::*;

  localparam int NR = 4;
  localparam int MB = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] req = '0;
  logic [2:0]    busy_len = '0;
  logic          busy;
  logic [NR-1:0] gnt;
  logic [1:0]    gnt_id;
  logic          len_clamped;
  state_e        dbg_state;

  busy_gnt_arbiter #(.NUM_REQ(NR), .MAX_BUSY(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .busy_len    (busy_len),
    .busy        (busy),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .len_clamped (len_clamped),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    busy_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  // Each row gives the outputs expected in this cycle and then the inputs
  // that are driven for this cycle.
  typedef struct {
    logic [NR-1:0] req;
    logic [2:0]    len;
    logic          e_busy;
    logic [NR-1:0] e_gnt;
    logic [1:0]    e_id;
    logic          e_clamp;
  } vec_t;
  vec_t vecs[15];

  // ---------------- scoreboard model ----------------
  typedef struct packed {
    logic          busy;
    logic [NR-1:0] gnt;
    logic [1:0]    id;
    logic          clamp;
  } out_t;
  out_t exp_q[$];
  int   ptr_m;

  // Applies the spec rules to one acceptance: round-robin from ptr_m,
  // length clamp, N busy cycles, then one grant cycle.
  task automatic model_accept(input logic [NR-1:0] r, input logic [2:0] len);
    int w;
    int n;
    logic cl;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr_m + k) % NR;
      if (w < 0 && r[idx]) w = idx;
    end
    if (len == 0) n = 1;
    else if (len > MB) n = MB;
    else n = len;
    cl = (len == 0) || (len > MB);
    for (int c = 0; c < n; c++)
      exp_q.push_back('{busy: 1'b1, gnt: '0, id: 2'(w), clamp: (c == 0) ? cl : 1'b0});
    exp_q.push_back('{busy: 1'b0, gnt: NR'(1) << w, id: 2'(w), clamp: 1'b0});
    ptr_m = (w + 1) % NR;
  endtask

  logic [NR-1:0] exp_gnts[3];
  int g_cyc[$];
  logic [NR-1:0] g_val[$];
  int fair_cnt[NR];
  int prev_id;
  logic saw_gnt;
  out_t cur;

  initial begin
    // 15 rows: single request (len 2), zero-length clamp, and over-length clamp
    vecs[0]  = '{4'b0001, 3'd2, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[3]  = '{4'b0000, 3'd0, 1'b0, 4'b0001, 2'd0, 1'b0};
    vecs[4]  = '{4'b0001, 3'd0, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[5]  = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd0, 1'b1};
    vecs[6]  = '{4'b0000, 3'd0, 1'b0, 4'b0001, 2'd0, 1'b0};
    vecs[7]  = '{4'b0100, 3'd7, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[8]  = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd2, 1'b1};
    vecs[9]  = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[10] = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[11] = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[12] = '{4'b0000, 3'd0, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[13] = '{4'b0000, 3'd0, 1'b0, 4'b0100, 2'd2, 1'b0};
    vecs[14] = '{4'b0000, 3'd0, 1'b0, 4'b0000, 2'd0, 1'b0};

    // ---- reset state ----
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_id", 32'(gnt_id), 32'd0);
    check("rst_clamp", 32'(len_clamped), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // ---- table-driven vectors ----
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_clamp", i), 32'(len_clamped), 32'(vecs[i].e_clamp));
      if (vecs[i].e_busy || vecs[i].e_gnt != '0)
        check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(vecs[i].e_id));
      req = vecs[i].req;
      busy_len = vecs[i].len;
    end

    // ---- contention: req=1010 held, len 1 -> ids 1,3,1, one busy between ----
    do_reset();
    req = 4'b1010;
    busy_len = 3'd1;
    exp_gnts[0] = 4'b0010;
    exp_gnts[1] = 4'b1000;
    exp_gnts[2] = 4'b0010;
    g_cyc.delete();
    g_val.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_cyc.push_back(c);
        g_val.push_back(gnt);
        check("cont_busy_excl", 32'(busy), 32'd0);
      end
      if (g_cyc.size() == 3) break;
    end
    req = '0;
    check("cont_gnt_count", 32'(g_cyc.size()), 32'd3);
    for (int i = 0; i < g_val.size() && i < 3; i++)
      check($sformatf("cont_gnt%0d", i), 32'(g_val[i]), 32'(exp_gnts[i]));
    for (int i = 1; i < g_cyc.size(); i++)
      check($sformatf("cont_gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);

    // ---- reset mid-BUSY ----
    do_reset();
    req = 4'b0100;
    busy_len = 3'd5;
    @(negedge clk);
    req = '0;
    check("mid_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy3", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_gnt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gnt != '0 || busy) saw_gnt = 1'b1;
    end
    check("mid_no_gnt", 32'(saw_gnt), 32'd0);
    req = 4'b1110;
    busy_len = 3'd1;
    @(negedge clk);
    req = '0;
    check("mid_next_busy", 32'(busy), 32'd1);
    check("mid_next_id", 32'(gnt_id), 32'd1);
    @(negedge clk);
    check("mid_next_gnt", 32'(gnt), 32'b0010);

    // ---- fairness: all requesters held 40 cycles, len 3 ----
    do_reset();
    req = 4'b1111;
    busy_len = 3'd3;
    for (int i = 0; i < NR; i++) fair_cnt[i] = 0;
    prev_id = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        fair_cnt[gnt_id]++;
        if (prev_id >= 0)
          check("fair_order", 32'(gnt_id), 32'((prev_id + 1) % NR));
        prev_id = int'(gnt_id);
      end
    end
    req = '0;
    for (int i = 0; i < NR; i++)
      check($sformatf("fair_cnt%0d", i), 32'(fair_cnt[i] >= 2), 32'd1);

    // ---- random stimulus against the scoreboard model ----
    do_reset();
    exp_q.delete();
    ptr_m = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{busy: 1'b0, gnt: '0, id: 2'd0, clamp: 1'b0};
      check("rnd_busy", 32'(busy), 32'(cur.busy));
      check("rnd_gnt", 32'(gnt), 32'(cur.gnt));
      check("rnd_clamp", 32'(len_clamped), 32'(cur.clamp));
      if (cur.busy || cur.gnt != '0)
        check("rnd_id", 32'(gnt_id), 32'(cur.id));
      req = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(1, 15));
      busy_len = 3'($urandom_range(0, 7));
      if (exp_q.size() == 0 && req != '0) model_accept(req, busy_len);
    end
    req = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
